sensor_conv: RTL and testbench



---
 rtl/sensor_conv_pkg.sv | 19 +
 rtl/shift_add_mul16.sv | 44 ++++
 rtl/sensor_conv.sv | 108 ++++++++++
 tb/tb_sensor_conv.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_conv_pkg.sv
// Shared types and constants for the sensor_conv raw-word to engineering-unit converter.
package sensor_conv_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ADJ} state_t;

  localparam logic [14:0] COEF_T_DEF = 15'd17572;
  localparam logic [15:0] OFFS_T_DEF = 16'd4685;
  localparam logic [14:0] COEF_H_DEF = 15'd12500;
  localparam logic [15:0] OFFS_H_DEF = 16'd600;
  localparam logic [15:0] RH_MAX_DEF = 16'd10000;

  localparam int unsigned KIND_BIT    = 1;
  localparam logic [15:0] STATUS_MASK = 16'hFFFC;

  function automatic logic [15:0] raw_code(input logic [15:0] raw);
    return raw & STATUS_MASK;
  endfunction

endpackage

// File: rtl/shift_add_mul16.sv
// 16x15 serial LSB-first shift-add multiplier; one iteration per clock, 16 iterations.
module shift_add_mul16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [14:0] b,
  output logic        done,
  output logic [30:0] product
);

  logic [15:0] a_sh;
  logic [30:0] b_sh;
  logic [3:0]  cnt;
  logic        run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_sh    <= a;
      b_sh    <= {16'd0, b};
      cnt     <= '0;
      run     <= 1'b1;
      product <= '0;
    end else if (run) begin
      if (a_sh[0])
        product <= product + b_sh;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh << 1;
      cnt  <= cnt + 4'd1;
      if (cnt == 4'd15)
        run <= 1'b0;
    end
  end

  // High during the final iteration, so the product is complete right after this edge.
  assign done = run && (cnt == 4'd15);

endmodule

// File: rtl/sensor_conv.sv
// Converts raw I2C temperature/humidity words to centi-degC / centi-percent.
// Optional humidity clamp to 0..RH_MAX: define SENSOR_CONV_CLAMP_EN.
module sensor_conv
  import sensor_conv_pkg::*;
#(
  parameter logic [14:0] COEF_T = COEF_T_DEF,
  parameter logic [15:0] OFFS_T = OFFS_T_DEF,
  parameter logic [14:0] COEF_H = COEF_H_DEF,
  parameter logic [15:0] OFFS_H = OFFS_H_DEF,
  parameter logic [15:0] RH_MAX = RH_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        measure_done,
  input  logic [15:0] i2c_data,
  output logic [15:0] temp_cdeg,
  output logic [15:0] humi_cpct,
  output logic        temp_valid,
  output logic        humi_valid,
  output logic        busy,
  output logic        overrun
);

  state_t      state, state_nxt;
  logic        kind_q;
  logic        start;
  logic [14:0] coef_sel;
  logic        mul_done;
  logic [30:0] mul_prod;
  logic [15:0] offs_sel;
  logic [16:0] diff;
  logic [15:0] humi_val;

  assign start    = (state == IDLE) && measure_done;
  assign coef_sel = i2c_data[KIND_BIT] ? COEF_H : COEF_T;
  assign busy     = (state != IDLE);

  shift_add_mul16 u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (raw_code(i2c_data)),
    .b       (coef_sel),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (measure_done) state_nxt = MUL;
      MUL:     if (mul_done)     state_nxt = ADJ;
      ADJ:                       state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Signed 17-bit (product >> 16) - offset; two's-complement bits match unsigned subtraction.
  always_comb begin
    offs_sel = kind_q ? OFFS_H : OFFS_T;
    diff     = 17'(mul_prod >> 16) - {1'b0, offs_sel};
`ifdef SENSOR_CONV_CLAMP_EN
    if (diff[16])
      humi_val = '0;
    else if (diff[15:0] > RH_MAX)
      humi_val = RH_MAX;
    else
      humi_val = diff[15:0];
`else
    humi_val = diff[15:0];
`endif
  end

`ifndef SENSOR_CONV_CLAMP_EN
  logic unused_clamp;
  assign unused_clamp = &{1'b0, diff[16], RH_MAX};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kind_q     <= 1'b0;
      temp_cdeg  <= '0;
      humi_cpct  <= '0;
      temp_valid <= 1'b0;
      humi_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      temp_valid <= 1'b0;
      humi_valid <= 1'b0;
      if (start)
        kind_q <= i2c_data[KIND_BIT];
      if (measure_done && state != IDLE)
        overrun <= 1'b1;
      if (state == ADJ) begin
        if (kind_q) begin
          humi_cpct  <= humi_val;
          humi_valid <= 1'b1;
        end else begin
          temp_cdeg  <= diff[15:0];
          temp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_conv.sv
// Self-checking bench for sensor_conv: scoreboard of expected conversions plus directed checks.
module tb_sensor_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        measure_done = 1'b0;
  logic [15:0] i2c_data = '0;
  logic [15:0] temp_cdeg, humi_cpct;
  logic        temp_valid, humi_valid, busy, overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        kind;
    logic [15:0] val;
    int          due;
  } exp_t;
  exp_t sb[$];

  sensor_conv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .measure_done (measure_done),
    .i2c_data     (i2c_data),
    .temp_cdeg    (temp_cdeg),
    .humi_cpct    (humi_cpct),
    .temp_valid   (temp_valid),
    .humi_valid   (humi_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [15:0] raw);
    longint code, p, v;
    code = longint'(raw & 16'hFFFC);
    if (raw[1]) begin
      p = code * 12500;
      v = (p >>> 16) - 600;
`ifdef SENSOR_CONV_CLAMP_EN
      if (v < 0) v = 0;
      if (v > 10000) v = 10000;
`endif
    end else begin
      p = code * 17572;
      v = (p >>> 16) - 4685;
    end
    return v[15:0];
  endfunction

  // Output monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (temp_valid || humi_valid)) begin
      checks++;
      if (temp_valid && humi_valid) begin
        errors++;
        $display("FAIL both_valid: temp_valid=%b humi_valid=%b, required one", temp_valid, humi_valid);
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: temp_valid=%b humi_valid=%b at cycle %0d, required none",
                 temp_valid, humi_valid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (humi_valid !== e.kind) begin
          errors++;
          $display("FAIL kind: humi_valid=%b, required %b", humi_valid, e.kind);
        end
        checks++;
        if ((e.kind ? humi_cpct : temp_cdeg) !== e.val) begin
          errors++;
          $display("FAIL value: got %h, required %h (kind=%b)",
                   e.kind ? humi_cpct : temp_cdeg, e.val, e.kind);
        end
        checks++;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL latency: valid at cycle %0d, required %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic pulse(input logic [15:0] raw, input bit accept);
    exp_t e;
    @(negedge clk);
    i2c_data     = raw;
    measure_done = 1'b1;
    if (accept) begin
      e.kind = raw[1];
      e.val  = model(raw);
      e.due  = cyc + 18;
      sb.push_back(e);
    end
    @(negedge clk);
    measure_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL timeout: pending=%0d busy=%b, required drained", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({temp_cdeg, humi_cpct, temp_valid, humi_valid, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_state: t=%h h=%h tv=%b hv=%b busy=%b ovr=%b, required all 0",
               temp_cdeg, humi_cpct, temp_valid, humi_valid, busy, overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_temp();
    pulse(16'h6650, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: busy=%b, required 1", busy);
    end
    wait_idle();
    check16("temp_2337", temp_cdeg, 16'd2337);
    check16("humi_untouched", humi_cpct, 16'd0);
  endtask

  task automatic test_humi();
    pulse(16'h7C82, 1);
    wait_idle();
    check16("humi_5479", humi_cpct, 16'd5479);
    check16("temp_held", temp_cdeg, 16'd2337);
  endtask

  task automatic test_extremes();
    pulse(16'h0000, 1);
    wait_idle();
    check16("temp_min", temp_cdeg, 16'hEDB3);
    pulse(16'h0002, 1);
    wait_idle();
`ifdef SENSOR_CONV_CLAMP_EN
    check16("humi_min", humi_cpct, 16'd0);
`else
    check16("humi_min", humi_cpct, 16'hFDA8);
`endif
    pulse(16'hFFFE, 1);
    wait_idle();
`ifdef SENSOR_CONV_CLAMP_EN
    check16("humi_max", humi_cpct, 16'd10000);
`else
    check16("humi_max", humi_cpct, 16'd11899);
`endif
  endtask

  task automatic test_back_to_back();
    pulse(16'h5A10, 1);
    repeat (16) @(negedge clk);
    pulse(16'h3C46, 1);
    wait_idle();
    check16("overrun_clear", {15'd0, overrun}, 16'd0);
  endtask

  task automatic test_overrun();
    pulse(16'h4000, 1);
    repeat (4) @(negedge clk);
    pulse(16'h9002, 0);
    check16("overrun_set", {15'd0, overrun}, 16'd1);
    wait_idle();
    repeat (30) @(negedge clk);
    check16("overrun_sticky", {15'd0, overrun}, 16'd1);
  endtask

  task automatic test_reset_mid();
    pulse(16'h6650, 1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({temp_cdeg, humi_cpct, temp_valid, humi_valid, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_mid: t=%h h=%h tv=%b hv=%b busy=%b ovr=%b, required all 0",
               temp_cdeg, humi_cpct, temp_valid, humi_valid, busy, overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pulse(16'h7C82, 1);
    wait_idle();
    check16("after_reset_humi", humi_cpct, 16'd5479);
  endtask

  task automatic test_alternation();
    logic [15:0] raws [3];
    raws[0] = 16'h8A3C;
    raws[1] = 16'hB0F6;
    raws[2] = 16'h1234 & 16'hFFFD;
    for (int unsigned i = 0; i < 3; i++) begin
      pulse(raws[i], 1);
      repeat (998) @(negedge clk);
      wait_idle();
    end
    check16("alt_temp", temp_cdeg, model(raws[2]));
    check16("alt_humi", humi_cpct, model(raws[1]));
  endtask

  initial begin
    test_reset();
    test_temp();
    test_humi();
    test_extremes();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_alternation();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
